rsa4k_host_seq: RTL and testbench

//  Hardware initiator for the rsa4k go/done core. Collects message, exponent and modulus as a stream of WORD-bit

---
 rtl/rsa4k_host_seq_if.sv | 22 ++
 rtl/rsa4k_host_seq.sv | 122 ++++++++++++
 tb/tb_rsa4k_host_seq.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rsa4k_host_seq_if.sv
// Word-stream bus between a host and rsa4k_host_seq: operand words in, result words out.
interface rsa4k_host_seq_if #(
  parameter int WORD = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [WORD-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_last;
  logic [WORD-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/rsa4k_host_seq.sv
// Streams message/exponent/modulus into an rsa4k go/done core, runs it, and streams cypher back out.
//
// state  | meaning
// LOAD   | accepting operand words (seg: 0 msg, 1 exp, 2 mod; idx: word within operand)
// ARM    | operands complete, waiting for a stale core_done to clear
// RUN    | core_go held high until core_done or timeout
// UNLOAD | presenting result words, LS word first
module rsa4k_host_seq #(
  parameter int WIDTH   = 4096,
  parameter int WORD    = 32,
  parameter int TIMEOUT = 0
) (
  input  logic             clk,
  input  logic             reset,
  rsa4k_host_seq_if.slave  bus,
  output logic             busy,
  output logic             timeout_err,
  output logic             core_go,
  output logic [WIDTH-1:0] core_message,
  output logic [WIDTH-1:0] core_exponent,
  output logic [WIDTH-1:0] core_modulus,
  input  logic [WIDTH-1:0] core_cypher,
  input  logic             core_done
);
  localparam int N  = WIDTH / WORD;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {LOAD, ARM, RUN, UNLOAD} state_t;

  state_t           state, state_nx;
  logic [1:0]       seg;
  logic [IW-1:0]    idx;
  logic [31:0]      tmr;
  logic [WIDTH-1:0] res;
  logic             idx_end, in_fire, out_fire, tmo;

  assign idx_end  = (idx == IW'(N - 1));
  assign in_fire  = (state == LOAD) && bus.in_valid;
  assign out_fire = (state == UNLOAD) && bus.out_ready;
  assign tmo      = (TIMEOUT != 0) && (tmr == 32'd0);

  assign bus.out_data = res[WORD-1:0];
  assign bus.out_last = (state == UNLOAD) && idx_end;
  assign busy         = !((state == LOAD) && (seg == 2'd0) && (idx == '0));

  always_comb begin
    state_nx      = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    case (state)
      LOAD: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && (seg == 2'd2) && idx_end) state_nx = ARM;
      end
      ARM:  if (!core_done) state_nx = RUN;
      RUN: begin
        if (core_done)  state_nx = UNLOAD;
        else if (tmo)   state_nx = LOAD;
      end
      UNLOAD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready && idx_end) state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  // Operands shift in from the top so word k lands at [k*WORD +: WORD] after N accepts;
  // the result shifts out from the bottom, avoiding wide variable-index muxes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= LOAD;
      seg           <= 2'd0;
      idx           <= '0;
      tmr           <= 32'd0;
      res           <= '0;
      core_message  <= '0;
      core_exponent <= '0;
      core_modulus  <= '0;
      core_go       <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        LOAD: if (in_fire) begin
          timeout_err <= 1'b0;
          case (seg)
            2'd0:    core_message  <= {bus.in_data, core_message[WIDTH-1:WORD]};
            2'd1:    core_exponent <= {bus.in_data, core_exponent[WIDTH-1:WORD]};
            default: core_modulus  <= {bus.in_data, core_modulus[WIDTH-1:WORD]};
          endcase
          if (idx_end) begin
            idx <= '0;
            seg <= (seg == 2'd2) ? 2'd0 : seg + 2'd1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ARM: if (!core_done) begin
          core_go <= 1'b1;
          tmr     <= 32'(TIMEOUT - 1);
        end
        RUN: begin
          if (core_done) begin
            res     <= core_cypher;
            core_go <= 1'b0;
          end else if (tmo) begin
            core_go     <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            tmr <= tmr - 32'd1;
          end
        end
        UNLOAD: if (out_fire) begin
          res <= res >> WORD;
          idx <= idx_end ? '0 : idx + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rsa4k_host_seq.sv
// Directed bench for rsa4k_host_seq: 64-bit instance (TIMEOUT=20) and 4096-bit instance, each with a stub core.
module tb_rsa4k_host_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  rsa4k_host_seq_if #(.WORD(32)) b64 ();
  rsa4k_host_seq_if #(.WORD(32)) b4k ();

  logic        busy64, terr64, go64;
  logic [63:0] msg64, exp64, mod64;
  logic [63:0] cyph64 = 64'd0;
  logic        done64 = 1'b0;

  logic          busy4, terr4, go4;
  logic [4095:0] msg4, exp4, mod4;
  logic [4095:0] cyph4 = {128{32'hA5A5A5A5}};
  logic          done4 = 1'b0;

  rsa4k_host_seq #(.WIDTH(64), .WORD(32), .TIMEOUT(20)) dut64 (
    .clk(clk), .reset(reset), .bus(b64), .busy(busy64), .timeout_err(terr64),
    .core_go(go64), .core_message(msg64), .core_exponent(exp64), .core_modulus(mod64),
    .core_cypher(cyph64), .core_done(done64)
  );

  rsa4k_host_seq #(.WIDTH(4096), .WORD(32), .TIMEOUT(0)) dut4k (
    .clk(clk), .reset(reset), .bus(b4k), .busy(busy4), .timeout_err(terr4),
    .core_go(go4), .core_message(msg4), .core_exponent(exp4), .core_modulus(mod4),
    .core_cypher(cyph4), .core_done(done4)
  );

  // 64-bit stub: done seen by the DUT on the stub_d-th edge of go; optionally held high afterwards.
  int   gocnt = 0;
  int   stub_d = 5;
  logic stub_en = 1'b1;
  logic stub_hold = 1'b0;
  always @(posedge clk) begin
    if (go64) gocnt <= gocnt + 1; else gocnt <= 0;
    if (go64 && stub_en && gocnt == stub_d - 2) done64 <= 1'b1;
    else if (!go64 && !stub_hold)              done64 <= 1'b0;
  end

  always @(posedge clk) done4 <= go4;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send64(input logic [31:0] w);
    int n = 0;
    b64.in_valid = 1'b1;
    b64.in_data  = w;
    while (!b64.in_ready && n < 50) begin tick(); n++; end
    check("in_ready64", 64'(b64.in_ready), 64'd1);
    tick();
    b64.in_valid = 1'b0;
  endtask

  task automatic load64(input logic [63:0] m, input logic [63:0] e, input logic [63:0] d);
    send64(m[31:0]); send64(m[63:32]);
    send64(e[31:0]); send64(e[63:32]);
    send64(d[31:0]); send64(d[63:32]);
  endtask

  task automatic recv64(input logic [31:0] w, input logic last, input string tag);
    int n = 0;
    b64.out_ready = 1'b1;
    while (!b64.out_valid && n < 100) begin tick(); n++; end
    check({tag, "_valid"}, 64'(b64.out_valid), 64'd1);
    check({tag, "_data"}, 64'(b64.out_data), 64'(w));
    check({tag, "_last"}, 64'(b64.out_last), 64'(last));
    tick();
    b64.out_ready = 1'b0;
  endtask

  task automatic wait_go64();
    int n = 0;
    while (!go64 && n < 100) begin tick(); n++; end
    check("go64_rise", 64'(go64), 64'd1);
  endtask

  task automatic count_go64(output int c);
    c = 0;
    while (go64 && c < 200) begin c++; tick(); end
  endtask

  task automatic send4k(input logic [31:0] w);
    int n = 0;
    b4k.in_valid = 1'b1;
    b4k.in_data  = w;
    while (!b4k.in_ready && n < 50) begin tick(); n++; end
    check("in_ready4k", 64'(b4k.in_ready), 64'd1);
    tick();
    b4k.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, j, n;
    logic rdy;
    logic [31:0] w;
    b64.in_valid = 1'b0; b64.in_data = '0; b64.out_ready = 1'b0;
    b4k.in_valid = 1'b0; b4k.in_data = '0; b4k.out_ready = 1'b0;

    // reset state
    tick();
    check("rst_busy", 64'(busy64), 64'd0);
    check("rst_go", 64'(go64), 64'd0);
    check("rst_out_valid", 64'(b64.out_valid), 64'd0);
    check("rst_terr", 64'(terr64), 64'd0);
    check("rst_msg", msg64, 64'd0);
    check("rst_out_data", 64'(b64.out_data), 64'd0);
    tick(); tick();
    reset = 1'b0;
    tick();

    // 1: 8^13 mod 77 = 50
    cyph64 = 64'd50;
    load64(64'd8, 64'd13, 64'd77);
    check("t1_arm_go", 64'(go64), 64'd0);
    check("t1_arm_in_ready", 64'(b64.in_ready), 64'd0);
    check("t1_arm_busy", 64'(busy64), 64'd1);
    tick();
    check("t1_go_latency", 64'(go64), 64'd1);
    check("t1_msg", msg64, 64'd8);
    check("t1_exp", exp64, 64'd13);
    check("t1_mod", mod64, 64'd77);
    count_go64(c);
    check("t1_go_cycles", 64'(c), 64'd5);
    check("t1_first_valid", 64'(b64.out_valid), 64'd1);
    recv64(32'd50, 1'b0, "t1w0");
    recv64(32'd0, 1'b1, "t1w1");
    check("t1_end_valid", 64'(b64.out_valid), 64'd0);
    check("t1_end_busy", 64'(busy64), 64'd0);

    // 2: 4096-bit full load
    for (int s = 0; s < 3; s++)
      for (int k = 0; k < 128; k++) begin
        w = (32'(s + 1) << 28) | 32'(k);
        send4k(w);
      end
    check("t2_msg_w0", 64'(msg4[31:0]), 64'h1000_0000);
    check("t2_msg_w127", 64'(msg4[4095:4064]), 64'h1000_007F);
    check("t2_exp_w0", 64'(exp4[31:0]), 64'h2000_0000);
    check("t2_mod_w127", 64'(mod4[4095:4064]), 64'h3000_007F);
    n = 0;
    while (!b4k.out_valid && n < 100) begin tick(); n++; end
    b4k.out_ready = 1'b1;
    for (int k = 0; k < 128; k++) begin
      check("t2_valid", 64'(b4k.out_valid), 64'd1);
      check("t2_data", 64'(b4k.out_data), 64'hA5A5_A5A5);
      check("t2_last", 64'(b4k.out_last), 64'(k == 127));
      tick();
    end
    b4k.out_ready = 1'b0;
    check("t2_end_valid", 64'(b4k.out_valid), 64'd0);

    // 3: out_ready toggling, done held high afterwards for test 4
    stub_hold = 1'b1;
    cyph64 = 64'h1234_5678_9ABC_DEF0;
    load64(64'h1234_5678_9ABC_DEF0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF);
    wait_go64();
    n = 0;
    while (!b64.out_valid && n < 100) begin tick(); n++; end
    j = 0; rdy = 1'b0; n = 0;
    while (j < 2 && n < 20) begin
      b64.out_ready = rdy;
      check("t3_valid", 64'(b64.out_valid), 64'd1);
      check("t3_data", 64'(b64.out_data), (j == 0) ? 64'h9ABC_DEF0 : 64'h1234_5678);
      check("t3_last", 64'(b64.out_last), 64'(j == 1));
      if (rdy) j++;
      rdy = ~rdy;
      tick();
      n++;
    end
    b64.out_ready = 1'b0;
    check("t3_words", 64'(j), 64'd2);
    check("t3_end_valid", 64'(b64.out_valid), 64'd0);

    // 4: stale done holds ARM; 2^10 mod 1000 = 24
    cyph64 = 64'd24;
    load64(64'd2, 64'd10, 64'd1000);
    for (int k = 0; k < 5; k++) begin
      check("t4_arm_go", 64'(go64), 64'd0);
      tick();
    end
    check("t4_arm_busy", 64'(busy64), 64'd1);
    stub_hold = 1'b0;
    wait_go64();
    count_go64(c);
    check("t4_go_cycles", 64'(c), 64'd5);
    recv64(32'd24, 1'b0, "t4w0");
    recv64(32'd0, 1'b1, "t4w1");

    // 5: timeout after 20 RUN cycles
    stub_en = 1'b0;
    load64(64'd8, 64'd13, 64'd77);
    wait_go64();
    count_go64(c);
    check("t5_go_cycles", 64'(c), 64'd20);
    check("t5_terr", 64'(terr64), 64'd1);
    check("t5_busy", 64'(busy64), 64'd0);
    for (int k = 0; k < 3; k++) begin
      check("t5_no_valid", 64'(b64.out_valid), 64'd0);
      tick();
    end
    stub_en = 1'b1;
    cyph64 = 64'd50;
    send64(32'd8);
    check("t5_terr_clear", 64'(terr64), 64'd0);
    send64(32'd0); send64(32'd13); send64(32'd0); send64(32'd77); send64(32'd0);
    wait_go64();
    recv64(32'd50, 1'b0, "t5w0");
    recv64(32'd0, 1'b1, "t5w1");

    // 6: reset mid-load, then mid-RUN
    send64(32'd1); send64(32'd2); send64(32'd3);
    reset = 1'b1;
    #1;
    check("t6_load_busy", 64'(busy64), 64'd0);
    check("t6_load_msg", msg64, 64'd0);
    check("t6_load_exp", exp64, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    load64(64'd8, 64'd13, 64'd77);
    wait_go64();
    tick(); tick();
    reset = 1'b1;
    #1;
    check("t6_run_go", 64'(go64), 64'd0);
    check("t6_run_busy", 64'(busy64), 64'd0);
    check("t6_run_valid", 64'(b64.out_valid), 64'd0);
    check("t6_run_mod", mod64, 64'd0);
    tick();
    reset = 1'b0;
    tick();
    load64(64'd8, 64'd13, 64'd77);
    wait_go64();
    recv64(32'd50, 1'b0, "t6w0");
    recv64(32'd0, 1'b1, "t6w1");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
